// File: rtl/max1270_adc_emu.sv
// MAX1270 ADC responder: decodes the SPI control byte, strobes SSTRB, shifts a 12-bit code out on MISO.
// Optional MAX1270_EMU_RAMP_EN replaces I_CH_DATA with per-channel ramp counters.
module max1270_adc_emu #(
  parameter int SYNC_STAGES = 2,
  parameter int CONV_CLKS   = 4
) (
  input  logic        s_axil_clk,
  input  logic        s_axil_rst,
  input  logic        I_MAX1270_SCK,
  input  logic        I_MAX1270_CS,
  input  logic        I_MAX1270_MOSI,
  input  logic        I_MAX1270_SHDN,
  input  logic [95:0] I_CH_DATA,
  output logic        O_MAX1270_MISO,
  output logic        O_MAX1270_SSTRB,
  output logic [7:0]  O_CTRL_BYTE,
  output logic        O_CTRL_VALID,
  output logic        O_BUSY
);

  typedef enum logic [2:0] {IDLE, CTRL, CONV, STRB, DATA, DONE} state_t;
  state_t state;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync, shdn_sync;
  logic sck_q;

  always_ff @(posedge s_axil_clk or posedge s_axil_rst) begin
    if (s_axil_rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      shdn_sync <= '0;
      sck_q     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], I_MAX1270_SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], I_MAX1270_CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], I_MAX1270_MOSI};
      shdn_sync <= {shdn_sync[SYNC_STAGES-2:0], I_MAX1270_SHDN};
      sck_q     <= sck_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s, mosi_s, rise, fall, abort;
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_q;
  assign fall   = ~sck_s & sck_q;
  // Deselect or shutdown overrides any SCK edge seen in the same clock.
  assign abort  = cs_sync[SYNC_STAGES-1] | ~shdn_sync[SYNC_STAGES-1];

  logic [3:0]  bit_cnt;
  logic [3:0]  conv_cnt;
  logic [6:0]  ctrl_sh;
  logic [11:0] data_sh;
  logic [7:0]  ctrl_next;
  logic [2:0]  sel_next;
  logic [11:0] ch_word;

  assign ctrl_next = {ctrl_sh, mosi_s};
  assign sel_next  = ctrl_next[6:4];

`ifdef MAX1270_EMU_RAMP_EN
  logic [11:0] ramp [8];
  logic        data_done;

  assign data_done = (state == DATA) && fall && (bit_cnt == 4'd0) && !abort;
  assign ch_word   = ramp[sel_next];

  always_ff @(posedge s_axil_clk or posedge s_axil_rst) begin
    if (s_axil_rst) begin
      for (int i = 0; i < 8; i++) ramp[i] <= '0;
    end else if (data_done) begin
      ramp[O_CTRL_BYTE[6:4]] <= ramp[O_CTRL_BYTE[6:4]] + 12'd1;
    end
  end
`else
  assign ch_word = I_CH_DATA[32'(sel_next) * 12 +: 12];
`endif

  // O_CTRL_VALID is a single-clock pulse with no back-pressure; O_CTRL_BYTE holds until the next full byte.
  always_ff @(posedge s_axil_clk or posedge s_axil_rst) begin
    if (s_axil_rst) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      conv_cnt        <= '0;
      ctrl_sh         <= '0;
      data_sh         <= '0;
      O_MAX1270_MISO  <= 1'b0;
      O_MAX1270_SSTRB <= 1'b0;
      O_CTRL_BYTE     <= '0;
      O_CTRL_VALID    <= 1'b0;
    end else begin
      O_CTRL_VALID <= 1'b0;
      if (abort) begin
        state           <= IDLE;
        bit_cnt         <= '0;
        conv_cnt        <= '0;
        ctrl_sh         <= '0;
        data_sh         <= '0;
        O_MAX1270_MISO  <= 1'b0;
        O_MAX1270_SSTRB <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (rise && mosi_s) begin
              state          <= CTRL;
              ctrl_sh        <= 7'd1;
              bit_cnt        <= 4'd1;
              O_MAX1270_MISO <= 1'b0;
            end
          end
          CTRL: begin
            if (rise) begin
              ctrl_sh <= ctrl_next[6:0];
              if (bit_cnt == 4'd7) begin
                O_CTRL_BYTE  <= ctrl_next;
                O_CTRL_VALID <= 1'b1;
                data_sh      <= ch_word;
                conv_cnt     <= '0;
                bit_cnt      <= '0;
                state        <= CONV;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          CONV: begin
            if (fall) begin
              if (conv_cnt == 4'(CONV_CLKS - 1)) begin
                O_MAX1270_SSTRB <= 1'b1;
                conv_cnt        <= '0;
                state           <= STRB;
              end else begin
                conv_cnt <= conv_cnt + 4'd1;
              end
            end
          end
          STRB: begin
            if (fall) begin
              O_MAX1270_SSTRB <= 1'b0;
              O_MAX1270_MISO  <= data_sh[11];
              data_sh         <= {data_sh[10:0], 1'b0};
              bit_cnt         <= 4'd11;
              state           <= DATA;
            end
          end
          DATA: begin
            if (fall) begin
              if (bit_cnt == 4'd0) begin
                O_MAX1270_MISO <= 1'b0;
                state          <= DONE;
              end else begin
                O_MAX1270_MISO <= data_sh[11];
                data_sh        <= {data_sh[10:0], 1'b0};
                bit_cnt        <= bit_cnt - 4'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign O_BUSY = (state == CTRL) || (state == CONV) || (state == STRB) || (state == DATA);

endmodule

// File: tb/tb_max1270_adc_emu.sv
// Self-checking bench for max1270_adc_emu: table vectors, random frames and hand-written corner sequences.
module tb_max1270_adc_emu;

  localparam int CONV_CLKS = 4;
  localparam int HALF      = 50;
  localparam int DS        = 8 + CONV_CLKS;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck, cs, mosi, shdn;
  logic [95:0] ch_data;
  logic        miso, sstrb, ctrl_valid, busy;
  logic [7:0]  ctrl_byte;

  always #5 clk = ~clk;

  max1270_adc_emu #(.SYNC_STAGES(2), .CONV_CLKS(CONV_CLKS)) dut (
    .s_axil_clk      (clk),
    .s_axil_rst      (rst),
    .I_MAX1270_SCK   (sck),
    .I_MAX1270_CS    (cs),
    .I_MAX1270_MOSI  (mosi),
    .I_MAX1270_SHDN  (shdn),
    .I_CH_DATA       (ch_data),
    .O_MAX1270_MISO  (miso),
    .O_MAX1270_SSTRB (sstrb),
    .O_CTRL_BYTE     (ctrl_byte),
    .O_CTRL_VALID    (ctrl_valid),
    .O_BUSY          (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  logic [11:0] exp_q[$];
  int ramp_m[8];
  logic [7:0] last_ctrl;

  always @(posedge clk) if (ctrl_valid === 1'b1) valid_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  ctrl;
    int          lead;
    logic [11:0] code;
    logic [7:0]  exp_ctrl;
    logic [11:0] exp_word;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic sck_cycle(input logic b, output logic m, output logic s);
    mosi = b;
    #HALF;
    m = miso;
    s = sstrb;
    sck = 1'b1;
    #HALF;
    sck = 1'b0;
  endtask

  task automatic load_channels(input logic [7:0] ctrl, input logic [11:0] code);
    for (int i = 0; i < 8; i++) ch_data[i*12 +: 12] = 12'($urandom_range(0, 4095));
    ch_data[32'(ctrl[6:4]) * 12 +: 12] = code;
  endtask

  function automatic logic [11:0] model_word(input logic [7:0] ctrl, input logic [11:0] code);
`ifdef MAX1270_EMU_RAMP_EN
    return 12'(ramp_m[ctrl[6:4]]);
`else
    return code;
`endif
  endfunction

  // Drives lead zero bits, the control byte and the full conversion/data phase; checks against the model.
  task automatic run_frame(input logic [7:0] ctrl, input int lead, input logic [11:0] exp_word,
                           input bit active);
    int v0, r;
    logic m, s, b;
    logic [11:0] got;
    bit strb_ok, zero_ok;
    v0 = valid_cnt;
    got = '0;
    strb_ok = 1;
    zero_ok = 1;
    if (active) begin
      exp_q.push_back(exp_word);
      last_ctrl = ctrl;
    end
    for (int c = 0; c < lead + DS + 13; c++) begin
      r = c - lead;
      if (r < 0) b = 1'b0;
      else if (r < 8) b = ctrl[7 - r];
      else if (r < DS + 12) b = 1'($urandom_range(0, 1));
      else b = 1'b0;
      sck_cycle(b, m, s);
      if (r == 9) for (int i = 0; i < 8; i++) ch_data[i*12 +: 12] = 12'($urandom_range(0, 4095));
      if (s !== (active && r == DS - 1)) strb_ok = 0;
      if (active && r >= DS && r < DS + 12) got[11 - (r - DS)] = m;
      else if (m !== 1'b0) zero_ok = 0;
    end
    mosi = 1'b0;
    #20;
    check("ctrl_valid_pulses", 32'(valid_cnt - v0), active ? 32'd1 : 32'd0);
    check("ctrl_byte", {24'd0, ctrl_byte}, {24'd0, last_ctrl});
    check("sstrb_window", {31'd0, strb_ok}, 32'd1);
    check("miso_idle_zero", {31'd0, zero_ok}, 32'd1);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    if (active) begin
      check("miso_word", {20'd0, got}, {20'd0, exp_q.pop_front()});
`ifdef MAX1270_EMU_RAMP_EN
      ramp_m[ctrl[6:4]] = (ramp_m[ctrl[6:4]] + 1) % 4096;
`endif
    end
  endtask

  task automatic full_frame(input logic [7:0] ctrl, input int lead, input logic [11:0] code);
    load_channels(ctrl, code);
    cs = 1'b0;
    #20;
    run_frame(ctrl, lead, model_word(ctrl, code), 1);
    cs = 1'b1;
    #60;
  endtask

  initial begin
    logic m, s;
    logic [7:0] rc;
    logic [11:0] code;
    int v0;

    vecs[0] = '{8'hD0, 0, 12'hA5C, 8'hD0, 12'hA5C};
    vecs[1] = '{8'h80, 3, 12'h001, 8'h80, 12'h001};
    vecs[2] = '{8'hFF, 1, 12'hFFF, 8'hFF, 12'hFFF};
    vecs[3] = '{8'hAE, 0, 12'h800, 8'hAE, 12'h800};
    vecs[4] = '{8'hF1, 2, 12'h7FE, 8'hF1, 12'h7FE};

    for (int i = 0; i < 8; i++) ramp_m[i] = 0;
    last_ctrl = 8'h00;
    rst = 1'b1; sck = 1'b0; cs = 1'b1; mosi = 1'b0; shdn = 1'b1; ch_data = '0;
    repeat (5) @(negedge clk);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_sstrb", {31'd0, sstrb}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ctrl_byte", {24'd0, ctrl_byte}, 32'd0);
    check("reset_ctrl_valid", {31'd0, ctrl_valid}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table vectors: the expected word follows the channel code unless the ramp build is selected.
    for (int i = 0; i < 5; i++) begin
      load_channels(vecs[i].ctrl, vecs[i].code);
      cs = 1'b0;
      #20;
`ifdef MAX1270_EMU_RAMP_EN
      run_frame(vecs[i].ctrl, vecs[i].lead, model_word(vecs[i].ctrl, vecs[i].code), 1);
`else
      run_frame(vecs[i].ctrl, vecs[i].lead, vecs[i].exp_word, 1);
`endif
      check("vec_ctrl_byte", {24'd0, ctrl_byte}, {24'd0, vecs[i].exp_ctrl});
      cs = 1'b1;
      #60;
    end

    // Randomized frames.
    for (int i = 0; i < 16; i++) begin
      rc = 8'($urandom_range(0, 255)) | 8'h80;
      code = 12'($urandom_range(0, 4095));
      full_frame(rc, $urandom_range(0, 3), code);
    end

    // Back-to-back frames without releasing CS; the second START comes from DONE.
    load_channels(8'hA2, 12'h3C3);
    cs = 1'b0;
    #20;
    run_frame(8'hA2, 0, model_word(8'hA2, 12'h3C3), 1);
    load_channels(8'h93, 12'h5A6);
    run_frame(8'h93, 2, model_word(8'h93, 12'h5A6), 1);
    cs = 1'b1;
    #60;

    // Abort after five control bits.
    v0 = valid_cnt;
    cs = 1'b0;
    #20;
    sck_cycle(1'b1, m, s);
    sck_cycle(1'b0, m, s);
    sck_cycle(1'b1, m, s);
    sck_cycle(1'b1, m, s);
    sck_cycle(1'b0, m, s);
    #30;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    cs = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_busy_after", {31'd0, busy}, 32'd0);
    check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("abort_ctrl_byte", {24'd0, ctrl_byte}, {24'd0, last_ctrl});
    #40;
    full_frame(8'h80, 0, 12'h7E1);

    // Shutdown held low for a whole frame.
    shdn = 1'b0;
    load_channels(8'hD0, 12'hFFF);
    cs = 1'b0;
    #20;
    run_frame(8'hD0, 0, 12'h000, 0);
    cs = 1'b1;
    shdn = 1'b1;
    #60;
    full_frame(8'hC4, 1, 12'h1B7);

    // Reset asserted in the middle of the data phase.
    load_channels(8'hD0, 12'hFFF);
    cs = 1'b0;
    #20;
    for (int c = 0; c < DS + 4; c++) sck_cycle(c < 8 ? vecs[0].ctrl[7 - c] : 1'b0, m, s);
    #30;
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_miso", {31'd0, miso}, 32'd0);
    check("rst_mid_sstrb", {31'd0, sstrb}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ctrl_byte", {24'd0, ctrl_byte}, 32'd0);
    rst = 1'b0;
    cs = 1'b1;
    last_ctrl = 8'h00;
    for (int i = 0; i < 8; i++) ramp_m[i] = 0;
    repeat (6) @(negedge clk);

`ifdef MAX1270_EMU_RAMP_EN
    for (int i = 0; i < 4; i++) full_frame(8'h80, 0, 12'(i));
`endif
    full_frame(8'hB8, 0, 12'h0F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
